// File: rtl/accum_sequencer.sv
// accum_sequencer: control stage in front of a 16-bit load/transfer accumulator.
// Operands arrive on a valid/ready handshake and wait in a small FIFO. A start
// request clears the accumulator, then one load/transfer pulse pair is issued
// per operand until the programmed operand count has been summed.
module accum_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             acc_clear_n,
    output logic             acc_load,
    output logic             acc_transfer,
    output logic [WIDTH-1:0] acc_data,
    output logic             busy,
    output logic             done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   remaining_reg;

    logic [WIDTH-1:0]   mem_reg [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        fill_reg;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (fill_reg == (AW+1)'(DEPTH));
    assign empty = (fill_reg == '0);
    // A full FIFO refuses input even while it is being popped, so in_ready
    // never depends on the FSM.
    assign push  = in_valid && !full;
    assign pop   = (state_reg == FETCH) && !empty;

    // Storage: each entry captures in_data when the write pointer selects it.
    // Data entries carry no reset; validity is tracked by fill_reg alone.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy; clear flushes the queue, done does not.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Sequencer: clear, then alternate FETCH/ADD once per operand, then DONE.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        remaining_reg <= count;
                        state_reg     <= CLR;
                    end
                end
                CLR: begin
                    state_reg <= (remaining_reg == '0) ? DONE : FETCH;
                end
                FETCH: begin
                    // An empty FIFO simply stalls here until an operand arrives.
                    if (!empty) begin
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    remaining_reg <= remaining_reg - CNT_W'(1);
                    state_reg     <= (remaining_reg == CNT_W'(1)) ? DONE : FETCH;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded only from flops (state, FIFO occupancy) plus the
    // reset input, so they settle right after the edge. clear forces the
    // accumulator clear directly so both are reset together.
    assign in_ready     = !full;
    assign acc_clear_n  = !(clear || (state_reg == CLR));
    assign acc_load     = (state_reg == FETCH) && !empty;
    assign acc_transfer = (state_reg == ADD);
    assign acc_data     = mem_reg[rd_ptr_reg];
    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);

endmodule
